// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage with register file, immediates and an ID/EX register
// Load-use stalls insert one bubble; EX flush kills the ID/EX entry.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RA_W   = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            wb_regWrite,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_writeData,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_readData1,
  output logic [XLEN-1:0] ex_readData2,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_i30,
  output logic [1:0]      ex_ALUOp,
  output logic            ex_ALUSrc,
  output logic            ex_branch,
  output logic            ex_memRead,
  output logic            ex_memToReg,
  output logic            ex_memWrite,
  output logic            ex_regWrite,
  output logic [1:0]      ex_jumpType,
  output logic            hazard_stall
);

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] jump_type;
  } ctl_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [XLEN-1:0] regs_q [NREG];

  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic            rs1_used, rs2_used, transfer;
  logic [31:0]     imm32;
  logic signed [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rdata1, rdata2;
  ctl_t            ctl_d;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  logic            i30_q;
  ctl_t            ctl_q;

  assign opcode = if_instr[6:0];
  assign rs1    = RA_W'(if_instr[19:15]);
  assign rs2    = RA_W'(if_instr[24:20]);
  assign rd     = RA_W'(if_instr[11:7]);

  always_comb begin
    ctl_d    = '0;
    imm32    = '0;
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BR);
    case (opcode)
      OP_REG: begin
        ctl_d.alu_op = 2'b10; ctl_d.reg_write = 1'b1;
      end
      OP_IMM: begin
        ctl_d.alu_op = 2'b10; ctl_d.alu_src = 1'b1; ctl_d.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_LOAD: begin
        ctl_d.alu_src = 1'b1; ctl_d.mem_read = 1'b1;
        ctl_d.mem_to_reg = 1'b1; ctl_d.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_STORE: begin
        ctl_d.alu_src = 1'b1; ctl_d.mem_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OP_BR: begin
        ctl_d.alu_op = 2'b01; ctl_d.branch = 1'b1;
        imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                 if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        ctl_d.jump_type = 2'b10; ctl_d.reg_write = 1'b1;
        imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                 if_instr[20], if_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctl_d.jump_type = 2'b01; ctl_d.alu_src = 1'b1; ctl_d.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        ctl_d.alu_src = 1'b1; ctl_d.reg_write = 1'b1;
        imm32 = {if_instr[31:12], 12'b0};
      end
      default: ctl_d = '0;
    endcase
  end

  assign imm_ext = $signed(imm32);

  // Same-cycle WB forwarding is selected at elaboration time.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != '0 && 32'(rs1) < NREG) rdata1 = regs_q[rs1];
    if (rs2 != '0 && 32'(rs2) < NREG) rdata2 = regs_q[rs2];
    if (BYPASS && wb_regWrite && wb_rd != '0) begin
      if (wb_rd == rs1) rdata1 = wb_writeData;
      if (wb_rd == rs2) rdata2 = wb_writeData;
    end
  end

  assign hazard_stall = valid_q & ctl_q.mem_read & (rd_q != '0) &
                        ((rs1_used & (rs1 == rd_q)) | (rs2_used & (rs2 == rd_q)));
  assign id_ready     = (~valid_q | ex_ready) & ~hazard_stall & ~flush;
  assign transfer     = if_valid & id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_regWrite && wb_rd != '0 && 32'(wb_rd) < NREG) begin
      regs_q[wb_rd] <= wb_writeData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      i30_q    <= 1'b0;
      ctl_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
    end else if (~valid_q | ex_ready) begin
      valid_q <= transfer;
      if (transfer) begin
        pc_q     <= if_pc;
        rd1_q    <= rdata1;
        rd2_q    <= rdata2;
        imm_q    <= imm_ext;
        rs1_q    <= rs1;
        rs2_q    <= rs2;
        rd_q     <= rd;
        funct3_q <= if_instr[14:12];
        i30_q    <= if_instr[30];
        ctl_q    <= ctl_d;
      end else begin
        ctl_q <= '0;
      end
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_readData1 = rd1_q;
  assign ex_readData2 = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_funct3    = funct3_q;
  assign ex_i30       = i30_q;
  assign ex_ALUOp     = ctl_q.alu_op;
  assign ex_ALUSrc    = ctl_q.alu_src;
  assign ex_branch    = ctl_q.branch;
  assign ex_memRead   = ctl_q.mem_read;
  assign ex_memToReg  = ctl_q.mem_to_reg;
  assign ex_memWrite  = ctl_q.mem_write;
  assign ex_regWrite  = ctl_q.reg_write;
  assign ex_jumpType  = ctl_q.jump_type;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed bench for id_stage_pipe
// A second instance with BYPASS=0 shares all stimulus.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_writeData;

  logic        id_ready, ex_valid, ex_i30, ex_ALUSrc, ex_branch, ex_memRead;
  logic        ex_memToReg, ex_memWrite, ex_regWrite, hazard_stall;
  logic [31:0] ex_pc, ex_readData1, ex_readData2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_ALUOp, ex_jumpType;

  logic        b_id_ready, b_ex_valid, b_ex_i30, b_ex_ALUSrc, b_ex_branch, b_ex_memRead;
  logic        b_ex_memToReg, b_ex_memWrite, b_ex_regWrite, b_hazard_stall;
  logic [31:0] b_ex_pc, b_ex_readData1, b_ex_readData2, b_ex_imm;
  logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
  logic [2:0]  b_ex_funct3;
  logic [1:0]  b_ex_ALUOp, b_ex_jumpType;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREG(32), .RA_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_writeData(wb_writeData),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_readData1(ex_readData1),
    .ex_readData2(ex_readData2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_i30(ex_i30), .ex_ALUOp(ex_ALUOp),
    .ex_ALUSrc(ex_ALUSrc), .ex_branch(ex_branch), .ex_memRead(ex_memRead),
    .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
    .ex_jumpType(ex_jumpType), .hazard_stall(hazard_stall)
  );

  id_stage_pipe #(.XLEN(32), .NREG(32), .RA_W(5), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(b_id_ready), .flush(flush), .ex_ready(ex_ready),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_writeData(wb_writeData),
    .ex_valid(b_ex_valid), .ex_pc(b_ex_pc), .ex_readData1(b_ex_readData1),
    .ex_readData2(b_ex_readData2), .ex_imm(b_ex_imm), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2),
    .ex_rd(b_ex_rd), .ex_funct3(b_ex_funct3), .ex_i30(b_ex_i30), .ex_ALUOp(b_ex_ALUOp),
    .ex_ALUSrc(b_ex_ALUSrc), .ex_branch(b_ex_branch), .ex_memRead(b_ex_memRead),
    .ex_memToReg(b_ex_memToReg), .ex_memWrite(b_ex_memWrite), .ex_regWrite(b_ex_regWrite),
    .ex_jumpType(b_ex_jumpType), .hazard_stall(b_hazard_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
    ex_ready = 1'b1; wb_regWrite = 1'b0; wb_rd = 5'd0; wb_writeData = 32'h0;
    tick; tick;
    rst = 1'b0;
    check("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_ex_pc", ex_pc, 32'h0);

    // write x7 then read it through add x8,x7,x0
    wb_regWrite = 1'b1; wb_rd = 5'd7; wb_writeData = 32'h0000_1234;
    tick;
    wb_regWrite = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0003_8433; if_pc = 32'h100;
    #1 check("idle_id_ready", {31'b0, id_ready}, 32'h1);
    tick;
    check("rf_x7_valid", {31'b0, ex_valid}, 32'h1);
    check("rf_x7_read", ex_readData1, 32'h0000_1234);
    check("rf_x7_rd", {27'b0, ex_rd}, 32'd8);
    check("rf_x7_pc", ex_pc, 32'h100);

    // T1: asynchronous reset mid-stream
    if_instr = 32'h0050_0093;
    rst = 1'b1;
    #1;
    check("t1_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("t1_ex_readData1", ex_readData1, 32'h0);
    check("t1_ex_pc", ex_pc, 32'h0);
    check("t1_ex_regWrite", {31'b0, ex_regWrite}, 32'h0);
    tick;
    rst = 1'b0;
    if_instr = 32'h0003_8433; if_pc = 32'h104;
    tick;
    check("t1_x7_cleared", ex_readData1, 32'h0);

    // T2: WB writes x5 in the cycle add x6,x5,x0 is decoded
    wb_regWrite = 1'b1; wb_rd = 5'd5; wb_writeData = 32'hDEAD_BEEF;
    if_instr = 32'h0002_8333; if_pc = 32'h108;
    tick;
    wb_regWrite = 1'b0;
    check("t2_bypass1", ex_readData1, 32'hDEAD_BEEF);
    check("t2_bypass0", b_ex_readData1, 32'h0);
    tick;
    check("t2_written_nobyp", b_ex_readData1, 32'hDEAD_BEEF);

    // T3: load-use hazard
    if_instr = 32'h0000_A103; if_pc = 32'h200;
    tick;
    check("t3_lw_memRead", {31'b0, ex_memRead}, 32'h1);
    check("t3_lw_rd", {27'b0, ex_rd}, 32'd2);
    if_instr = 32'h0021_01B3; if_pc = 32'h204;
    #1;
    check("t3_hazard", {31'b0, hazard_stall}, 32'h1);
    check("t3_id_ready", {31'b0, id_ready}, 32'h0);
    tick;
    check("t3_bubble_valid", {31'b0, ex_valid}, 32'h0);
    check("t3_bubble_regWrite", {31'b0, ex_regWrite}, 32'h0);
    check("t3_hazard_clear", {31'b0, hazard_stall}, 32'h0);
    tick;
    check("t3_add_valid", {31'b0, ex_valid}, 32'h1);
    check("t3_add_pc", ex_pc, 32'h204);
    check("t3_add_rd", {27'b0, ex_rd}, 32'd3);

    // T4: backpressure hold for three cycles
    if_instr = 32'h0050_0093; if_pc = 32'h300;
    tick;
    check("t4_imm", ex_imm, 32'd5);
    ex_ready = 1'b0;
    if_instr = 32'h0002_8333; if_pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      #1 check("t4_id_ready", {31'b0, id_ready}, 32'h0);
      tick;
      check("t4_hold_imm", ex_imm, 32'd5);
      check("t4_hold_rd", {27'b0, ex_rd}, 32'd1);
      check("t4_hold_pc", ex_pc, 32'h300);
    end
    ex_ready = 1'b1;
    tick;
    check("t4_next_pc", ex_pc, 32'h304);
    check("t4_next_rd", {27'b0, ex_rd}, 32'd6);

    // T5: flush with backpressure and a valid IF instruction
    ex_ready = 1'b0; flush = 1'b1;
    if_instr = 32'h0050_0093; if_pc = 32'h400;
    #1 check("t5_id_ready", {31'b0, id_ready}, 32'h0);
    tick;
    check("t5_valid", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    tick;
    check("t5_not_accepted", {31'b0, ex_valid}, 32'h0);
    check("t5_pc_kept", ex_pc, 32'h304);

    // T6: x0 and immediates
    if_valid = 1'b1; if_instr = 32'h0070_0013; if_pc = 32'h500;
    tick;
    check("t6_addi_imm", ex_imm, 32'd7);
    check("t6_addi_rd", {27'b0, ex_rd}, 32'd0);
    wb_regWrite = 1'b1; wb_rd = 5'd0; wb_writeData = 32'h0000_FFFF;
    if_instr = 32'h0000_00B3; if_pc = 32'h504;
    tick;
    wb_regWrite = 1'b0;
    check("t6_x0_rd1", ex_readData1, 32'h0);
    check("t6_x0_rd2", ex_readData2, 32'h0);
    if_instr = 32'hFFDF_F0EF; if_pc = 32'h508;
    tick;
    check("t6_jal_imm", ex_imm, 32'hFFFF_FFFC);
    check("t6_jal_jump", {30'b0, ex_jumpType}, 32'h2);
    if_valid = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
